// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch and variable-latency data memory.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ID_rs1,
    input  logic [4:0] ID_rs2,
    input  logic       ID_EX_MemRead,
    input  logic [4:0] ID_EX_rd,
    input  logic       EX_Mem_MemRead,
    input  logic       EX_Mem_MemWrite,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       PC_Write,
    output logic       IF_ID_Write,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Write,
    output logic       ID_EX_Flush,
    output logic       EX_Mem_Write,
    output logic       Mem_WB_Bubble,
    output logic       mem_error
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    // state    | meaning
    // RUN      | normal flow; load-use and branch responses apply
    // MEM_WAIT | data memory access outstanding, wait_cnt counts stalled cycles
    // ERROR    | memory timed out; pipeline frozen until reset
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;

    logic mem_acc, mem_stall, load_use;
    logic pc_wr_c, ifid_wr_c, ifid_fl_c, idex_wr_c, idex_fl_c, exmem_wr_c, bubble_c, err_c;

    assign mem_acc   = EX_Mem_MemRead | EX_Mem_MemWrite;
    assign mem_stall = mem_acc & ~mem_ready & (state != ERROR);
    assign load_use  = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                       ((ID_EX_rd == ID_rs1) || (ID_EX_rd == ID_rs2));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        pc_wr_c      = 1'b1;
        ifid_wr_c    = 1'b1;
        ifid_fl_c    = 1'b0;
        idex_wr_c    = 1'b1;
        idex_fl_c    = 1'b0;
        exmem_wr_c   = 1'b1;
        bubble_c     = 1'b0;
        err_c        = 1'b0;

        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == CNT_LAST) begin
                    state_nxt = ERROR;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = ERROR;
        endcase

        // A stall holds a taken branch in EX/Mem; its flush fires in the release cycle.
        if (state == ERROR) begin
            pc_wr_c    = 1'b0;
            ifid_wr_c  = 1'b0;
            idex_wr_c  = 1'b0;
            exmem_wr_c = 1'b0;
            bubble_c   = 1'b1;
            err_c      = 1'b1;
        end else if (mem_stall) begin
            pc_wr_c    = 1'b0;
            ifid_wr_c  = 1'b0;
            idex_wr_c  = 1'b0;
            exmem_wr_c = 1'b0;
            bubble_c   = 1'b1;
        end else if (branch_taken) begin
            ifid_fl_c = 1'b1;
            idex_fl_c = 1'b1;
        end else if (load_use) begin
            pc_wr_c   = 1'b0;
            ifid_wr_c = 1'b0;
            idex_fl_c = 1'b1;
        end
    end

    assign PC_Write      = reset & pc_wr_c;
    assign IF_ID_Write   = reset & ifid_wr_c;
    assign IF_ID_Flush   = reset & ifid_fl_c;
    assign ID_EX_Write   = reset & idex_wr_c;
    assign ID_EX_Flush   = reset & idex_fl_c;
    assign EX_Mem_Write  = reset & exmem_wr_c;
    assign Mem_WB_Bubble = reset & bubble_c;
    assign mem_error     = reset & err_c;

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_wr_c && (state != ERROR) && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;
            if (ifid_fl_c && (flush_count != '1))
                flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule
